cpu_core: RTL

Parametrised single-clock successor to the phase-clocked RISC CPU. Executes the same eight-opcode accumulator ISA (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP) with data and address widths set by parameters. An internal sequencer replaces the external fetch/control/ALU clocks. A unified instruction/data memory is reached through a req/ready handshake, so memories with wait states are supported.

---
 rtl/cpu_core_pkg.sv | 30 +++
 rtl/cpu_core_seq.sv | 54 +++++
 rtl/cpu_core.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared types for the cpu_core accumulator CPU.
//   opcode_t    - 3-bit instruction opcode (top three bits of every instruction word)
//   cpu_state_t - sequencer state
//   op_is_mem() - true for opcodes whose EXEC phase performs a memory transfer
package cpu_core_pkg;

    typedef enum logic [2:0] {
        OpHlt = 3'd0,
        OpSkz = 3'd1,
        OpAdd = 3'd2,
        OpAnd = 3'd3,
        OpXor = 3'd4,
        OpLda = 3'd5,
        OpSto = 3'd6,
        OpJmp = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        StReset,
        StFetch,
        StDecode,
        StExec,
        StHalt
    } cpu_state_t;

    function automatic logic op_is_mem(input opcode_t op);
        return (op == OpAdd) || (op == OpAnd) || (op == OpXor) || (op == OpLda) || (op == OpSto);
    endfunction

endpackage

// File: rtl/cpu_core_seq.sv
// cpu_core_seq: instruction sequencer for cpu_core.
// Holds the state register, steps RESET -> FETCH -> DECODE -> EXEC -> FETCH (or HALT on HLT)
// and decodes the memory request controls from state and opcode.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   op_i           - opcode of the instruction held in the instruction register
//   mem_ready_i    - memory accepts the current request this cycle
//   state_o        - current sequencer state
//   mem_req_o      - memory request (combinational from state/opcode)
//   mem_we_o       - write strobe, only for STO in EXEC
module cpu_core_seq
    import cpu_core_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  opcode_t    op_i,
    input  logic       mem_ready_i,
    output cpu_state_t state_o,
    output logic       mem_req_o,
    output logic       mem_we_o
);

    cpu_state_t state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StReset;
        end else begin
            unique case (state_q)
                StReset:  state_q <= StFetch;
                StFetch:  if (mem_ready_i) state_q <= StDecode;
                StDecode: state_q <= (op_i == OpHlt) ? StHalt : StExec;
                // Non-memory instructions finish EXEC in one cycle; memory ones wait for ready.
                StExec:   if (!op_is_mem(op_i) || mem_ready_i) state_q <= StFetch;
                StHalt:   state_q <= StHalt;
                default:  state_q <= StReset;
            endcase
        end
    end

    always_comb begin
        mem_req_o = 1'b0;
        mem_we_o  = 1'b0;
        if (state_q == StFetch) begin
            mem_req_o = 1'b1;
        end else if (state_q == StExec && op_is_mem(op_i)) begin
            mem_req_o = 1'b1;
            mem_we_o  = (op_i == OpSto);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-clock eight-opcode accumulator CPU with a req/ready memory port.
// Optional feature macro: CPU_CORE_PERF_EN builds the 32-bit retired-instruction counter;
// without it retire_cnt_o is tied to zero.
// Parameters: DATA_W (word width, >= ADDR_W+3), ADDR_W (address/pc width), RESET_PC.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   mem_req_o/mem_we_o         - request and write strobe, held until mem_ready_i
//   mem_addr_o/mem_wdata_o     - access address, write data (accumulator)
//   mem_rdata_i/mem_ready_i    - read data sampled on the accepting edge, transfer complete
//   halt_o                     - core stopped on HLT
//   pc_o, accum_o              - debug views of pc and accumulator
//   retire_cnt_o               - retired-instruction count
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              halt_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] accum_o,
    output logic [31:0]       retire_cnt_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] accum_q, accum_d;

    cpu_state_t        state;
    opcode_t           op;
    logic [ADDR_W-1:0] ir_addr;
    logic              mem_xfer;
    logic              unused_ir;

    assign op        = opcode_t'(ir_q[DATA_W-1 -: 3]);
    assign ir_addr   = ir_q[ADDR_W-1:0];
    // Bits between the operand address and the opcode carry no meaning.
    assign unused_ir = ^ir_q;

    cpu_core_seq u_seq (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .op_i        (op),
        .mem_ready_i (mem_ready_i),
        .state_o     (state),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o)
    );

    assign mem_xfer = mem_req_o && mem_ready_i;

    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        accum_d = accum_q;
        unique case (state)
            StFetch: begin
                if (mem_xfer) ir_d = mem_rdata_i;
            end
            StDecode: begin
                pc_d = pc_q + ADDR_W'(1);
            end
            StExec: begin
                unique case (op)
                    OpAdd: if (mem_xfer) accum_d = accum_q + mem_rdata_i;
                    OpAnd: if (mem_xfer) accum_d = accum_q & mem_rdata_i;
                    OpXor: if (mem_xfer) accum_d = accum_q ^ mem_rdata_i;
                    OpLda: if (mem_xfer) accum_d = mem_rdata_i;
                    // pc already points past SKZ; a second increment skips one word.
                    OpSkz: if (accum_q == '0) pc_d = pc_q + ADDR_W'(1);
                    OpJmp: pc_d = ir_addr;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            accum_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            accum_q <= accum_d;
        end
    end

    // Address is stable through wait states: pc and ir only move on accepting edges.
    assign mem_addr_o  = (state == StFetch) ? pc_q : ir_addr;
    assign mem_wdata_o = accum_q;
    assign halt_o      = (state == StHalt);
    assign pc_o        = pc_q;
    assign accum_o     = accum_q;

`ifdef CPU_CORE_PERF_EN
    logic [31:0] retire_q;
    logic        retire_evt;

    // HLT retires at the end of DECODE, everything else at the end of EXEC.
    always_comb begin
        retire_evt = 1'b0;
        if (state == StDecode && op == OpHlt) begin
            retire_evt = 1'b1;
        end else if (state == StExec) begin
            retire_evt = !op_is_mem(op) || mem_xfer;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retire_q <= '0;
        end else if (retire_evt) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_cnt_o = retire_q;
`else
    assign retire_cnt_o = '0;
`endif

endmodule
